// File: rtl/weight_buffer_pkg.sv
// Shared sizing and state encoding for the butterfly weight buffer.
package weight_buffer_pkg;

    localparam int unsigned DATA_WIDTH      = 16;
    localparam int unsigned BU_PARALLELISM  = 4;
    localparam int unsigned MAX_LENGTH      = 32;
    localparam int unsigned ELEMS_PER_WORD  = 4 * BU_PARALLELISM;
    localparam int unsigned WORD_W          = DATA_WIDTH * ELEMS_PER_WORD;
    localparam int unsigned STAGE_DEPTH_MAX = (2 * MAX_LENGTH) / ELEMS_PER_WORD;
    localparam int unsigned MEM_DEPTH       = STAGE_DEPTH_MAX * $clog2(MAX_LENGTH);
    localparam int unsigned PTR_W           = $clog2(MEM_DEPTH + 1);
    localparam int unsigned ADDR_W          = $clog2(MEM_DEPTH);
    localparam int unsigned LEN_W           = 16;
    localparam int unsigned LOG_W           = $clog2(LEN_W);

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/weight_ram.sv
// Simple dual-port weight storage: one write port, one registered read port, no reset.
module weight_ram
    import weight_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_dat
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/weight_buffer.sv
// Buffers one transform's butterfly weights and replays them in write order on butterfly_start.
module weight_buffer
    import weight_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  length,
    input  logic              butterfly_start,
    input  logic              up_vld,
    input  logic [WORD_W-1:0] up_dat,
    output logic              up_rdy,
    output logic              dn_vld,
    output logic [WORD_W-1:0] dn_dat,
    input  logic              dn_rdy
);

    wb_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               dn_vld_d;
    logic               up_rdy_d;
    logic               wr_en_c;
    logic               rd_en_c;
    logic [LOG_W-1:0]   log2_len;
    logic [LEN_W-1:0]   stage_depth;
    logic [PTR_W-1:0]   total;
    logic [WORD_W-1:0]  ram_q;

    // Priority encoder: index of the highest set bit of a power-of-two length.
    always_comb begin
        log2_len = '0;
        for (int i = 0; i < LEN_W; i++) begin
            if (length[i]) log2_len = LOG_W'(i);
        end
    end

    assign stage_depth = LEN_W'((32'(length) * 32'd2) / 32'(ELEMS_PER_WORD));
    assign total       = PTR_W'(32'(stage_depth) * 32'(log2_len));

    // Next-state logic; a write in the start cycle still lands before replay begins.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dn_vld_d = dn_vld;
        wr_en_c  = 1'b0;
        rd_en_c  = 1'b0;
        case (state_q)
            LOAD: begin
                if (up_vld && up_rdy) begin
                    wr_en_c  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (butterfly_start) begin
                    state_d  = STREAM;
                    rd_ptr_d = '0;
                end
            end
            STREAM: begin
                // Refill the output register whenever it is empty or being drained.
                if ((!dn_vld || dn_rdy) && (rd_ptr_q < total)) begin
                    rd_en_c  = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    dn_vld_d = 1'b1;
                end else if (dn_vld && dn_rdy) begin
                    dn_vld_d = 1'b0;
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
        endcase
        up_rdy_d = (state_d == LOAD) && (wr_ptr_d < total);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dn_vld   <= 1'b0;
            up_rdy   <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dn_vld   <= dn_vld_d;
            up_rdy   <= up_rdy_d;
        end
    end

    weight_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (ADDR_W'(wr_ptr_q)),
        .wr_dat  (up_dat),
        .rd_en   (rd_en_c),
        .rd_addr (ADDR_W'(rd_ptr_q)),
        .rd_dat  (ram_q)
    );

    // RAM output has no reset; qualify it so the port reads zero whenever nothing is offered.
    assign dn_dat = dn_vld ? ram_q : '0;

endmodule

// File: tb/tb_weight_buffer.sv
// Randomized self-checking bench for weight_buffer against a write-order replay model.
module tb_weight_buffer;
    import weight_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       length;
    logic              butterfly_start;
    logic              up_vld;
    logic [WORD_W-1:0] up_dat;
    logic              up_rdy;
    logic              dn_vld;
    logic [WORD_W-1:0] dn_dat;
    logic              dn_rdy;

    int errors = 0;
    int checks = 0;
    logic [WORD_W-1:0] model_mem [MEM_DEPTH];
    int wr_cnt = 0;

    always #5 clk = ~clk;

    weight_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .length          (length),
        .butterfly_start (butterfly_start),
        .up_vld          (up_vld),
        .up_dat          (up_dat),
        .up_rdy          (up_rdy),
        .dn_vld          (dn_vld),
        .dn_dat          (dn_dat),
        .dn_rdy          (dn_rdy)
    );

    function automatic int total_words(int len);
        int lg = 0;
        int v = len;
        while (v > 1) begin
            v = v / 2;
            lg++;
        end
        return ((2 * len) / (4 * BU_PARALLELISM)) * lg;
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer n words (with random idle gaps); the model keeps only those that fit.
    task automatic load_words(input int n, input int gap_pct);
        int sent = 0;
        int guard = 0;
        bit exp_rdy;
        while (sent < n && guard < 1000) begin
            guard++;
            if ($urandom_range(99) < gap_pct) begin
                up_vld = 1'b0;
                step();
            end else begin
                up_vld = 1'b1;
                up_dat = rand_word();
                exp_rdy = (wr_cnt < total_words(int'(length)));
                checks++;
                if (up_rdy !== exp_rdy) begin
                    errors++;
                    $display("FAIL up_rdy_write%0d: got %b want %b", sent, up_rdy, exp_rdy);
                end
                if (exp_rdy) begin
                    model_mem[wr_cnt] = up_dat;
                    wr_cnt++;
                end
                step();
                sent++;
            end
        end
        up_vld = 1'b0;
    endtask

    // mode 0: dn_rdy high, 1: 1,0,0 pattern, 2: random. restart_at/reset_at are beat indices or -1.
    task automatic run_stream(input int mode, input int restart_at, input int reset_at);
        int n = total_words(int'(length));
        int beat = 0;
        int cyc = 0;
        int extra = 0;
        bit restarted = 0;
        bit prev_stall = 0;
        logic [WORD_W-1:0] prev = '0;
        dn_rdy = 1'b1;
        butterfly_start = 1'b1;
        step();
        butterfly_start = 1'b0;
        checks++;
        if (dn_vld !== 1'b0) begin
            errors++;
            $display("FAIL early_beat: dn_vld got %b want 0", dn_vld);
        end
        step();
        checks++;
        if (dn_vld !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_latency: dn_vld got %b want 1", dn_vld);
        end
        while (beat < n && cyc < 400) begin
            case (mode)
                0:       dn_rdy = 1'b1;
                1:       dn_rdy = (cyc % 3 == 0);
                default: dn_rdy = 1'($urandom_range(1));
            endcase
            if (restart_at >= 0 && beat == restart_at && !restarted) begin
                butterfly_start = 1'b1;
                restarted = 1;
            end else begin
                butterfly_start = 1'b0;
            end
            if (reset_at >= 0 && beat == reset_at) begin
                butterfly_start = 1'b0;
                rst_n = 1'b0;
                #1;
                checks++;
                if (dn_vld !== 1'b0 || dn_dat !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_stream: dn_vld=%b dn_dat=%h want 0/0", dn_vld, dn_dat);
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                step();
                checks++;
                if (up_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL up_rdy_after_reset: got %b want 1", up_rdy);
                end
                wr_cnt = 0;
                dn_rdy = 1'b1;
                return;
            end
            if (dn_vld) begin
                checks++;
                if (dn_dat !== model_mem[beat]) begin
                    errors++;
                    $display("FAIL replay_word%0d: got %h want %h", beat, dn_dat, model_mem[beat]);
                end
                if (prev_stall) begin
                    checks++;
                    if (dn_dat !== prev) begin
                        errors++;
                        $display("FAIL stall_stable%0d: got %h want %h", beat, dn_dat, prev);
                    end
                end
            end
            prev = dn_dat;
            prev_stall = dn_vld && !dn_rdy;
            if (dn_vld && dn_rdy) beat++;
            step();
            cyc++;
        end
        butterfly_start = 1'b0;
        dn_rdy = 1'b1;
        checks++;
        if (beat != n) begin
            errors++;
            $display("FAIL replay_timeout: beats got %0d want %0d", beat, n);
        end
        checks++;
        if (dn_vld !== 1'b0 || up_rdy !== 1'b1) begin
            errors++;
            $display("FAIL end_of_replay: dn_vld=%b up_rdy=%b want 0/1", dn_vld, up_rdy);
        end
        for (int i = 0; i < 5; i++) begin
            if (dn_vld === 1'b1) extra++;
            step();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL extra_beats: got %0d want 0", extra);
        end
        wr_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        length = 16'd32;
        butterfly_start = 1'b0;
        up_vld = 1'b0;
        up_dat = '0;
        dn_rdy = 1'b1;
        step();
        step();
        checks++;
        if (dn_vld !== 1'b0 || dn_dat !== '0 || up_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: dn_vld=%b dn_dat=%h up_rdy=%b want 0/0/1", dn_vld, dn_dat, up_rdy);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (up_rdy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_up_rdy: got %b want 1", up_rdy);
        end
    endtask

    task automatic test_full_load();
        load_words(20, 0);
        checks++;
        if (up_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_up_rdy: got %b want 0", up_rdy);
        end
        run_stream(0, -1, -1);
    endtask

    task automatic test_overflow();
        load_words(23, 0);
        run_stream(0, -1, -1);
    endtask

    task automatic test_backpressure();
        load_words(20, 30);
        run_stream(1, -1, -1);
        run_stream(2, -1, -1);
    endtask

    task automatic test_reset_mid_stream();
        load_words(20, 0);
        run_stream(0, -1, 7);
        load_words(20, 25);
        run_stream(2, -1, -1);
    endtask

    task automatic test_short_length();
        length = 16'd8;
        load_words(5, 0);
        checks++;
        if (up_rdy !== 1'b0) begin
            errors++;
            $display("FAIL short_full_up_rdy: got %b want 0", up_rdy);
        end
        run_stream(0, -1, -1);
        length = 16'd32;
    endtask

    task automatic test_start_ignored();
        load_words(20, 0);
        run_stream(0, 5, -1);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_overflow();
        test_backpressure();
        test_reset_mid_stream();
        test_short_length();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
